lcd_cmd_dispatcher: RTL and testbench

//  Upstream command stage for LCD_CTRL. Buffers 4-bit LCD opcodes from a host in a FIFO.

---
 rtl/lcd_cmd_dispatcher.sv | 158 +++++++++++++++
 tb/tb_lcd_cmd_dispatcher.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_dispatcher.sv
// Command stage in front of LCD_CTRL: queues host opcodes in a small FIFO and issues
// them one at a time, honouring the busy handshake and the Write/done frame handshake.
module lcd_cmd_dispatcher #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int BUSY_TO = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    in_cmd,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [3:0]    cmd,
    output logic          cmd_valid,
    input  logic          busy,
    input  logic          done,
    output logic          frame_done,
    output logic [AW:0]   fifo_level,
    output logic [7:0]    issued_cnt,
    output logic          illegal_cmd,
    output logic          timeout_err
);

    localparam int             TW       = (BUSY_TO < 2) ? 1 : $clog2(BUSY_TO);
    localparam logic [TW-1:0]  TO_LAST  = TW'(BUSY_TO - 1);
    localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [3:0]     OP_WRITE = 4'd0;
    localparam logic [3:0]     OP_LIMIT = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_IDLE,
        WAIT_FRAME
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q;
    logic [3:0]      cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            frame_done_q, frame_done_d;
    logic [7:0]      issued_cnt_q, issued_cnt_d;
    logic            illegal_q;
    logic            timeout_q, timeout_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    logic            empty, push, drop, pop;
    logic [3:0]      head;

    assign empty    = (level_q == '0);
    assign in_ready = (level_q != FULL_LVL);
    assign head     = mem[rd_ptr_q];
    assign push     = in_valid && in_ready && (in_cmd < OP_LIMIT);
    assign drop     = in_valid && in_ready && (in_cmd >= OP_LIMIT);

    // NOTE: FIFO storage is deliberately not reset; occupancy is tracked by the
    // pointers and level, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        issued_cnt_d = issued_cnt_q;
        timeout_d    = timeout_q;
        to_cnt_d     = to_cnt_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !busy) begin
                    pop          = 1'b1;
                    cmd_d        = head;
                    cmd_valid_d  = 1'b1;
                    issued_cnt_d = issued_cnt_q + 8'd1;
                    to_cnt_d     = '0;
                    state_d      = (head == OP_WRITE) ? WAIT_FRAME : WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (!busy) state_d = IDLE;
            end
            WAIT_FRAME: begin
                // Write completion is signalled by done only; busy is ignored here.
                if (done) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            issued_cnt_q <= '0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            frame_done_q <= frame_done_d;
            issued_cnt_q <= issued_cnt_d;
            timeout_q    <= timeout_d;
            to_cnt_q     <= to_cnt_d;
            if (drop) illegal_q <= 1'b1;
        end
    end

    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_done  = frame_done_q;
    assign fifo_level  = level_q;
    assign issued_cnt  = issued_cnt_q;
    assign illegal_cmd = illegal_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_lcd_cmd_dispatcher.sv
// Directed bench for lcd_cmd_dispatcher: a small LCD_CTRL busy model plus hand-computed
// expectations for ordering, back-pressure, Write/done, illegal opcodes, timeout and reset.
module tb_lcd_cmd_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       frame_done;
    logic [3:0] fifo_level;
    logic [7:0] issued_cnt;
    logic       illegal_cmd;
    logic       timeout_err;

    lcd_cmd_dispatcher #(.DEPTH(8), .AW(3), .BUSY_TO(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_cmd      (in_cmd),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cmd         (cmd),
        .cmd_valid   (cmd_valid),
        .busy        (busy),
        .done        (done),
        .frame_done  (frame_done),
        .fifo_level  (fifo_level),
        .issued_cnt  (issued_cnt),
        .illegal_cmd (illegal_cmd),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] issued_q[$];
    int         wide_cnt  = 0;
    int         frame_cnt = 0;
    logic       prev_cv   = 1'b0;
    bit         busy_auto = 1'b0;
    int         busy_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue log sampled on the active edge (sees the pre-edge values).
    always @(posedge clk) begin
        if (cmd_valid) issued_q.push_back(cmd);
        if (cmd_valid && prev_cv) wide_cnt++;
        prev_cv = cmd_valid;
        if (frame_done) frame_cnt++;
    end

    // LCD_CTRL model: busy high for two cycles starting right after each issue strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (busy_auto) begin
                if (cmd_valid) busy_left = 2;
                if (busy_left > 0) begin
                    busy = 1'b1;
                    busy_left--;
                end else begin
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [3:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        in_cmd   = c;
    endtask

    task automatic end_push();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!cmd_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, cmd_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp2 [9];
        bit         acc;
        int         nv;

        reset = 1'b0; in_valid = 1'b0; in_cmd = '0; busy = 1'b0; done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd",        cmd,         4'd0);
        check("rst_cmd_valid",  cmd_valid,   1'b0);
        check("rst_in_ready",   in_ready,    1'b1);
        check("rst_frame_done", frame_done,  1'b0);
        check("rst_level",      fifo_level,  4'd0);
        check("rst_issued",     issued_cnt,  8'd0);
        check("rst_illegal",    illegal_cmd, 1'b0);
        check("rst_timeout",    timeout_err, 1'b0);
        reset     = 1'b1;
        busy_auto = 1'b1;
        issued_q.delete();

        // 1: three commands in order, one-cycle strobes
        push(4'd1); push(4'd2); push(4'd3); end_push();
        repeat (20) @(negedge clk);
        check("t1_count", issued_q.size(), 3);
        for (int i = 0; i < 3 && i < issued_q.size(); i++)
            check($sformatf("t1_cmd%0d", i), issued_q[i], 4'(i + 1));
        check("t1_issued_cnt", issued_cnt, 8'd3);

        // 2: fill with busy stuck high, then drain and accept the ninth
        @(negedge clk);
        busy_auto = 1'b0; busy = 1'b1; busy_left = 0;
        issued_q.delete();
        for (int i = 0; i < 8; i++) push(4'(4 + i));
        push(4'd1);
        check("t2_full_ready", in_ready,   1'b0);
        check("t2_full_level", fifo_level, 4'd8);
        busy = 1'b0; busy_auto = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            if (in_ready) acc = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t2_ninth_accepted", acc, 1'b1);
        for (int k = 0; k < 150 && issued_q.size() < 9; k++) @(negedge clk);
        check("t2_count", issued_q.size(), 9);
        for (int i = 0; i < 8; i++) exp2[i] = 4'(4 + i);
        exp2[8] = 4'd1;
        for (int i = 0; i < 9 && i < issued_q.size(); i++)
            check($sformatf("t2_cmd%0d", i), issued_q[i], exp2[i]);
        check("t2_issued_cnt", issued_cnt, 8'd12);
        repeat (6) @(negedge clk);

        // 3: Write holds further issues until done, then frame_done pulses once
        push(4'd0); push(4'd5); end_push();
        wait_valid("t3_write_issue", 20);
        check("t3_write_cmd", cmd, 4'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("t3_hold%0d", i), cmd_valid, 1'b0);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("t3_frame_done", frame_done, 1'b1);
        check("t3_no_issue",   cmd_valid,  1'b0);
        @(negedge clk);
        check("t3_frame_once", frame_done, 1'b0);
        check("t3_next_valid", cmd_valid,  1'b1);
        check("t3_next_cmd",   cmd,        4'd5);
        repeat (8) @(negedge clk);

        // 4: illegal opcode dropped, sticky flag
        push(4'd13); end_push();
        check("t4_level",   fifo_level,  4'd0);
        check("t4_illegal", illegal_cmd, 1'b1);
        repeat (3) @(negedge clk);

        // 5: busy never rises -> timeout after 4 cycles, next command still issued
        busy_auto = 1'b0; busy = 1'b0; busy_left = 0;
        push(4'd4); push(4'd7); end_push();
        wait_valid("t5_issue", 20);
        check("t5_cmd", cmd, 4'd4);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check($sformatf("t5_no_timeout%0d", i), timeout_err, 1'b0);
        end
        @(negedge clk);
        check("t5_timeout", timeout_err, 1'b1);
        @(negedge clk);
        check("t5_next_valid", cmd_valid, 1'b1);
        check("t5_next_cmd",   cmd,       4'd7);
        check("t5_issued_cnt", issued_cnt, 8'd16);
        check("t5_illegal_sticky", illegal_cmd, 1'b1);
        repeat (6) @(negedge clk);

        // 6: reset during WAIT_IDLE with three commands still queued
        busy = 1'b1;
        push(4'd2); push(4'd3); push(4'd6); push(4'd8); end_push();
        check("t6_level4", fifo_level, 4'd4);
        busy = 1'b0;
        @(negedge clk);
        check("t6_issue", cmd_valid, 1'b1);
        check("t6_cmd",   cmd,       4'd2);
        busy = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_level3", fifo_level, 4'd3);
        check("t6_issued_cnt", issued_cnt, 8'd17);
        #2 reset = 1'b0;
        #1;
        check("t6_cmd_rst",        cmd,         4'd0);
        check("t6_cmd_valid_rst",  cmd_valid,   1'b0);
        check("t6_in_ready_rst",   in_ready,    1'b1);
        check("t6_frame_done_rst", frame_done,  1'b0);
        check("t6_level_rst",      fifo_level,  4'd0);
        check("t6_issued_rst",     issued_cnt,  8'd0);
        check("t6_illegal_rst",    illegal_cmd, 1'b0);
        check("t6_timeout_rst",    timeout_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        busy  = 1'b0;
        nv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cmd_valid) nv++;
        end
        check("t6_queue_flushed", nv, 0);
        check("t6_level_after",   fifo_level, 4'd0);

        check("strobe_width", wide_cnt,  0);
        check("frame_pulses", frame_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
